// File: rtl/datagen_pkg.sv
// Shared definitions for the datagen capture sequencer: default widths, arm length
// and the sequencer state encoding.
package datagen_pkg;

  localparam int DEF_FRAME_W    = 8;
  localparam int DEF_DELAY_W    = 32;
  localparam int DEF_NFRAMES_W  = 16;
  localparam int DEF_TIMEOUT_W  = 24;
  localparam int DEF_ARM_CYCLES = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FINISH = 3'd5,
    ST_ABORT  = 3'd6
  } seq_state_e;

  // States in which the datagen counter is kept running.
  function automatic logic is_running(input seq_state_e s);
    return s inside {ST_ARM, ST_SAMPLE, ST_CLEAR, ST_DRAIN};
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags expiry
// in the cycle the count reaches the limit. A zero limit disables it.
module seq_watchdog #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != '1) begin
      count <= count + W'(1);
    end
  end

  // count is 0 in the first watched cycle, so limit-1 marks the limit-th cycle.
  assign expire = enable && (limit != '0) && (count == limit - W'(1));

endmodule

// File: rtl/datagen_seq.sv
// Capture sequencer: latches a config on start, steps datagen through
// arm/sample/clear/drain for N frames, and ends with done_pulse or a timeout abort.
module datagen_seq
  import datagen_pkg::*;
#(
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int DELAY_W    = DEF_DELAY_W,
  parameter int NFRAMES_W  = DEF_NFRAMES_W,
  parameter int TIMEOUT_W  = DEF_TIMEOUT_W,
  parameter int ARM_CYCLES = DEF_ARM_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [FRAME_W-1:0]   cfg_frame_size,
  input  logic [DELAY_W-1:0]   cfg_delay,
  input  logic [NFRAMES_W-1:0] cfg_num_frames,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  output logic                 dg_en_ctr,
  output logic                 dg_en_sample,
  output logic                 dg_clr,
  output logic [FRAME_W-1:0]   dg_frame_size,
  output logic [DELAY_W-1:0]   dg_delay,
  input  logic                 dg_done,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic                 busy,
  output logic [NFRAMES_W-1:0] frames_done,
  output logic                 done_pulse,
  output logic                 err_timeout
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  seq_state_e           state, next_state;
  logic [NFRAMES_W-1:0] num_frames;
  logic [TIMEOUT_W-1:0] timeout_lim;
  logic [ARM_W-1:0]     arm_cnt;
  logic [NFRAMES_W:0]   frames_inc;
  logic                 beat, start_ok, last_frame, frame_beat;
  logic                 wd_expire, timeout_hit;

  assign beat       = mon_tvalid & mon_tready & mon_tlast;
  assign start_ok   = (state == ST_IDLE) && start;
  assign frames_inc = {1'b0, frames_done} + {{NFRAMES_W{1'b0}}, 1'b1};
  assign last_frame = (frames_inc == {1'b0, num_frames});

  seq_watchdog #(.W(TIMEOUT_W)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (next_state != state),
    .enable (state inside {ST_SAMPLE, ST_DRAIN}),
    .limit  (timeout_lim),
    .expire (wd_expire)
  );

  assign timeout_hit = wd_expire && !abort;
  assign frame_beat  = (state == ST_DRAIN) && beat && !abort && !wd_expire;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = (cfg_num_frames == '0) ? ST_FINISH : ST_ARM;
      ST_ARM:    if (arm_cnt == ARM_W'(ARM_CYCLES - 1)) next_state = ST_SAMPLE;
      ST_SAMPLE: if (dg_done) next_state = ST_CLEAR;
      ST_CLEAR:  next_state = ST_DRAIN;
      ST_DRAIN:  if (beat) next_state = last_frame ? ST_FINISH : ST_SAMPLE;
      ST_FINISH: next_state = ST_IDLE;
      ST_ABORT:  next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    // An abort during CLEAR skips ABORT: the clr pulse is already out, and a
    // second back-to-back clr cycle would break its one-cycle guarantee.
    if (state inside {ST_ARM, ST_SAMPLE, ST_DRAIN} && (abort || wd_expire)) begin
      next_state = ST_ABORT;
    end else if (state == ST_CLEAR && abort) begin
      next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      arm_cnt       <= '0;
      num_frames    <= '0;
      timeout_lim   <= '0;
      dg_frame_size <= '0;
      dg_delay      <= '0;
      dg_en_ctr     <= 1'b0;
      dg_en_sample  <= 1'b0;
      dg_clr        <= 1'b0;
      busy          <= 1'b0;
      frames_done   <= '0;
      done_pulse    <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state        <= next_state;
      arm_cnt      <= (state == ST_ARM) ? arm_cnt + ARM_W'(1) : '0;
      // Outputs decode next_state so they line up with the state they describe.
      dg_en_ctr    <= is_running(next_state);
      dg_en_sample <= (next_state == ST_SAMPLE);
      dg_clr       <= next_state inside {ST_CLEAR, ST_ABORT};
      busy         <= (next_state != ST_IDLE);
      done_pulse   <= (next_state == ST_FINISH);

      if (start_ok) begin
        num_frames    <= cfg_num_frames;
        timeout_lim   <= cfg_timeout;
        dg_frame_size <= cfg_frame_size;
        dg_delay      <= cfg_delay;
        frames_done   <= '0;
        err_timeout   <= 1'b0;
      end else begin
        if (frame_beat && frames_done != '1) begin
          frames_done <= frames_done + NFRAMES_W'(1);
        end
        if (timeout_hit) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_datagen_seq.sv
// Directed bench for datagen_seq: stimulus pushes the expected clr/done events,
// a negedge monitor pops and compares them as the DUT raises them.
module tb_datagen_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  cfg_frame_size;
  logic [31:0] cfg_delay;
  logic [15:0] cfg_num_frames;
  logic [23:0] cfg_timeout;
  logic        dg_en_ctr, dg_en_sample, dg_clr;
  logic [7:0]  dg_frame_size;
  logic [31:0] dg_delay;
  logic        dg_done, mon_tvalid, mon_tready, mon_tlast;
  logic        busy, done_pulse, err_timeout;
  logic [15:0] frames_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic        done;
    logic [15:0] frames;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  datagen_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_frame_size (cfg_frame_size),
    .cfg_delay      (cfg_delay),
    .cfg_num_frames (cfg_num_frames),
    .cfg_timeout    (cfg_timeout),
    .dg_en_ctr      (dg_en_ctr),
    .dg_en_sample   (dg_en_sample),
    .dg_clr         (dg_clr),
    .dg_frame_size  (dg_frame_size),
    .dg_delay       (dg_delay),
    .dg_done        (dg_done),
    .mon_tvalid     (mon_tvalid),
    .mon_tready     (mon_tready),
    .mon_tlast      (mon_tlast),
    .busy           (busy),
    .frames_done    (frames_done),
    .done_pulse     (done_pulse),
    .err_timeout    (err_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic clr, input logic done, input logic [15:0] frames,
                           input logic err);
    exp_t e;
    e.clr = clr; e.done = done; e.frames = frames; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every clr or done cycle must match the oldest expected event.
  always @(negedge clk) begin
    if (rst === 1'b0 && (dg_clr === 1'b1 || done_pulse === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got clr=%0b done=%0b frames=%0d, expected none",
                 dg_clr, done_pulse, frames_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ev_kind", {62'd0, dg_clr, done_pulse}, {62'd0, e.clr, e.done});
        check("ev_frames", frames_done, e.frames);
        check("ev_err", err_timeout, e.err);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic sel_val(input int sel);
    case (sel)
      0:       return dg_en_sample;
      1:       return dg_clr;
      2:       return done_pulse;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int limit, input string tag);
    for (int i = 0; i <= limit; i++) begin
      if (sel_val(sel) === 1'b1) return;
      cyc(1);
    end
    checks++;
    errors++;
    $display("FAIL %s: got no event within %0d cycles, expected one", tag, limit);
  endtask

  task automatic do_start(input logic [15:0] nf, input logic [23:0] tmo);
    cfg_frame_size = 8'd10;
    cfg_delay      = 32'd10;
    cfg_num_frames = nf;
    cfg_timeout    = tmo;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // One datagen frame: done after a few sample cycles, then a tlast beat in DRAIN.
  task automatic run_frame(input string tag);
    wait_until(0, 50, {tag, "_sample"});
    cyc(3);
    dg_done = 1'b1;
    cyc(1);
    dg_done = 1'b0;
    wait_until(1, 10, {tag, "_clr"});
    cyc(2);
    mon_tvalid = 1'b1;
    mon_tlast  = 1'b1;
    cyc(1);
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  initial begin
    int  k;
    logic saw_ctr;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dg_done = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tlast = 1'b0;
    cfg_frame_size = 8'd0; cfg_delay = 32'd0; cfg_num_frames = 16'd0; cfg_timeout = 24'd0;
    cyc(2);
    check("rst_outputs", {dg_en_ctr, dg_en_sample, dg_clr, busy, done_pulse, err_timeout}, 0);
    check("rst_frames", frames_done, 0);
    check("rst_cfg", {dg_frame_size, dg_delay}, 0);
    rst = 1'b0;
    cyc(1);

    // Nominal: 3 frames, cfg inputs disturbed after latching, stray start while busy.
    expect_ev(1, 0, 0, 0); expect_ev(1, 0, 1, 0); expect_ev(1, 0, 2, 0); expect_ev(0, 1, 3, 0);
    do_start(16'd3, 24'd0);
    cfg_frame_size = 8'd99; cfg_delay = 32'd77; cfg_num_frames = 16'd1;
    check("nom_arm_ctr", {dg_en_ctr, dg_en_sample, busy}, 3'b101);
    cyc(4);
    check("nom_arm_len", dg_en_sample, 0);
    cyc(1);
    check("nom_sample_rise", {dg_en_ctr, dg_en_sample}, 2'b11);
    run_frame("nom1");
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    run_frame("nom2");
    run_frame("nom3");
    check("nom_frames", frames_done, 3);
    cyc(2);
    check("nom_idle", {busy, dg_en_ctr, dg_en_sample}, 0);
    check("nom_cfg_held", {dg_frame_size, dg_delay}, {8'd10, 32'd10});

    // Backpressure: tlast held without tready, then non-last beats, then the last beat.
    expect_ev(1, 0, 0, 0); expect_ev(0, 1, 1, 0);
    do_start(16'd1, 24'd0);
    wait_until(0, 50, "bp_sample");
    dg_done = 1'b1;
    cyc(1);
    dg_done = 1'b0;
    wait_until(1, 10, "bp_clr");
    mon_tready = 1'b0; mon_tvalid = 1'b1; mon_tlast = 1'b1;
    cyc(50);
    check("bp_stall", {busy, dg_en_ctr, dg_en_sample}, 3'b110);
    check("bp_stall_frames", frames_done, 0);
    mon_tready = 1'b1; mon_tlast = 1'b0;
    cyc(3);
    check("bp_nonlast_frames", frames_done, 0);
    mon_tlast = 1'b1;
    cyc(1);
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    check("bp_last_frames", frames_done, 1);
    cyc(2);
    check("bp_idle", busy, 0);

    // Timeout: dg_done never arrives, watchdog fires after 100 SAMPLE cycles.
    expect_ev(1, 0, 0, 1);
    do_start(16'd2, 24'd100);
    wait_until(0, 20, "to_sample");
    k = 0;
    while (err_timeout !== 1'b1 && k < 200) begin
      cyc(1);
      k++;
    end
    check("to_cycle", k, 100);
    check("to_abort_outs", {dg_en_ctr, dg_en_sample, dg_clr}, 3'b001);
    cyc(1);
    check("to_idle", {busy, dg_clr}, 0);
    cyc(5);
    check("to_sticky", err_timeout, 1);

    // Abort mid-DRAIN of frame 2, then restart.
    expect_ev(1, 0, 0, 0); expect_ev(1, 0, 1, 0); expect_ev(1, 0, 1, 0);
    do_start(16'd3, 24'd0);
    check("ab_err_cleared", err_timeout, 0);
    run_frame("ab1");
    wait_until(0, 10, "ab2_sample");
    dg_done = 1'b1;
    cyc(1);
    dg_done = 1'b0;
    wait_until(1, 10, "ab2_clr");
    cyc(3);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("ab_outs", {dg_en_ctr, dg_en_sample, dg_clr, busy}, 4'b0011);
    cyc(1);
    check("ab_idle", {busy, dg_clr, done_pulse}, 0);
    check("ab_frames", frames_done, 1);
    expect_ev(1, 0, 0, 0); expect_ev(0, 1, 1, 0);
    do_start(16'd1, 24'd0);
    run_frame("re1");
    cyc(2);
    check("re_frames", {busy, frames_done}, {1'b0, 16'd1});

    // Zero frames: immediate completion, counter never enabled.
    expect_ev(0, 1, 0, 0);
    do_start(16'd0, 24'd0);
    wait_until(2, 2, "zero_done");
    saw_ctr = dg_en_ctr;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      saw_ctr = saw_ctr | dg_en_ctr;
    end
    check("zero_no_ctr", saw_ctr, 0);
    check("zero_frames", {busy, frames_done}, 0);

    // Reset mid-SAMPLE, with a stray start first.
    do_start(16'd3, 24'd50);
    wait_until(0, 20, "rs_sample");
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("rs_busy", {busy, dg_en_sample}, 2'b11);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rs_outputs", {dg_en_ctr, dg_en_sample, dg_clr, busy, done_pulse, err_timeout}, 0);
    check("rs_regs", {frames_done, dg_frame_size, dg_delay}, 0);
    cyc(3);
    check("rs_stays_idle", busy, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
